// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler: FSM state encoding,
// header magic nibble and the round-robin pick function.
package uart_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_NEXT      = 3'd4,
      ST_ACK       = 3'd5
   } sched_state_t;

   localparam logic [3:0] HDR_MAGIC = 4'hA;

   // First set bit of req at or after ptr, wrapping modulo n_req (n_req <= 8).
   function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                          input logic [2:0] ptr,
                                          input logic [3:0] n_req);
      logic [2:0] pick;
      logic       found;
      logic [3:0] idx;
      pick  = 3'd0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = {1'b0, ptr} + 4'(i);
         if (idx >= n_req) begin
            idx = idx - n_req;
         end else begin
            idx = idx;
         end
         if (!found && (4'(i) < n_req) && req[idx[2:0]]) begin
            pick  = idx[2:0];
            found = 1'b1;
         end else begin
            pick  = pick;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational pick from the current pointer, with the
// pointer advanced past the served requester when the scheduler acknowledges it.
module rr_arbiter
   import uart_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_REQ-1:0]  req,
   input  logic              adv,
   input  logic [ID_W-1:0]   adv_id,
   output logic              any_req,
   output logic [ID_W-1:0]   pick_id
);

   logic [ID_W-1:0] ptr_q;
   logic [ID_W-1:0] ptr_d;
   logic [7:0]      req_ext_s;

   // Pick the next requester and compute the pointer update.
   always_comb begin
      req_ext_s              = 8'h00;
      req_ext_s[N_REQ-1:0]   = req;
      any_req                = |req;
      pick_id                = ID_W'(rr_pick(req_ext_s, 3'(ptr_q), 4'(N_REQ)));
      if (adv) begin
         if (adv_id == ID_W'(N_REQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = adv_id + ID_W'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8-bit UART transmitter between N_REQ requesters, sending each
// captured word LSB byte first. Define UART_TX_SCHED_HEADER_EN to prefix every
// word with a header byte {HDR_MAGIC, 1'b0, grant_id[2:0]}.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int WORD_BYTES = 4,
   parameter int ID_W       = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ*WORD_BYTES*8-1:0] req_data,
   output logic [N_REQ-1:0]              ack,
   output logic [ID_W-1:0]               grant_id,
   output logic                          busy,
   output logic                          TxD_start,
   output logic [7:0]                    TxD_data,
   input  logic                          TxD_busy
);

   localparam int WORD_W = WORD_BYTES * 8;
`ifdef UART_TX_SCHED_HEADER_EN
   localparam int NBYTES = WORD_BYTES + 1;
`else
   localparam int NBYTES = WORD_BYTES;
`endif
   localparam int SH_W  = NBYTES * 8;
   localparam int CNT_W = 4;

   sched_state_t     state_q, state_d;
   logic [SH_W-1:0]  shift_q, shift_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [ID_W-1:0]  grant_id_q, grant_id_d;
   logic             busy_q, busy_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic             txd_start_q, txd_start_d;
   logic [7:0]       txd_data_q, txd_data_d;

   logic             any_req_s;
   logic [ID_W-1:0]  pick_id_s;
   logic             arb_adv_s;
   logic             last_s;
   logic [WORD_W-1:0] word_s;

   assign arb_adv_s = (state_q == ST_ACK);
   assign last_s    = (byte_cnt_q == CNT_W'(NBYTES - 1));
   assign word_s    = req_data[32'(pick_id_s) * WORD_W +: WORD_W];

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .adv     (arb_adv_s),
      .adv_id  (grant_id_q),
      .any_req (any_req_s),
      .pick_id (pick_id_s)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         byte_cnt_q  <= '0;
         grant_id_q  <= '0;
         busy_q      <= 1'b0;
         ack_q       <= '0;
         txd_start_q <= 1'b0;
         txd_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         byte_cnt_q  <= byte_cnt_d;
         grant_id_q  <= grant_id_d;
         busy_q      <= busy_d;
         ack_q       <= ack_d;
         txd_start_q <= txd_start_d;
         txd_data_q  <= txd_data_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req_s) state_d = ST_START;
            else           state_d = ST_IDLE;
         end
         ST_START: begin
            if (!TxD_busy) state_d = ST_WAIT_BUSY;
            else           state_d = ST_START;
         end
         ST_WAIT_BUSY: begin
            if (TxD_busy) state_d = ST_WAIT_DONE;
            else          state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_DONE: begin
            if (TxD_busy)    state_d = ST_WAIT_DONE;
            else if (last_s) state_d = ST_ACK;
            else             state_d = ST_NEXT;
         end
         ST_NEXT: state_d = ST_START;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and output logic; outputs are registered so each value appears one cycle after its decision.
   always_comb begin
      shift_d     = shift_q;
      byte_cnt_d  = byte_cnt_q;
      grant_id_d  = grant_id_q;
      busy_d      = busy_q;
      ack_d       = '0;
      txd_start_d = 1'b0;
      txd_data_d  = txd_data_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req_s) begin
               grant_id_d = pick_id_s;
               busy_d     = 1'b1;
               byte_cnt_d = '0;
`ifdef UART_TX_SCHED_HEADER_EN
               shift_d    = {word_s, HDR_MAGIC, 1'b0, 3'(pick_id_s)};
`else
               shift_d    = word_s;
`endif
            end else begin
               busy_d     = 1'b0;
            end
         end
         ST_START: begin
            if (!TxD_busy) begin
               txd_start_d = 1'b1;
               txd_data_d  = shift_q[7:0];
            end else begin
               txd_start_d = 1'b0;
            end
         end
         ST_WAIT_BUSY: begin
            txd_start_d = 1'b0;
         end
         ST_WAIT_DONE: begin
            if (!TxD_busy && last_s) begin
               ack_d[grant_id_q] = 1'b1;
            end else begin
               ack_d = '0;
            end
         end
         ST_NEXT: begin
            shift_d    = shift_q >> 4'd8;
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
         end
         ST_ACK: begin
            busy_d = 1'b0;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   assign ack       = ack_q;
   assign grant_id  = grant_id_q;
   assign busy      = busy_q;
   assign TxD_start = txd_start_q;
   assign TxD_data  = txd_data_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a behavioural transmitter model
// and a round-robin reference model; honours UART_TX_SCHED_HEADER_EN.
module tb_uart_tx_scheduler;

   localparam int N_REQ      = 4;
   localparam int WORD_BYTES = 4;
   localparam int ID_W       = 2;
   localparam int WORD_W     = WORD_BYTES * 8;

   logic                          clk = 1'b0;
   logic                          reset;
   logic [N_REQ-1:0]              req;
   logic [N_REQ*WORD_W-1:0]       req_data;
   logic [N_REQ-1:0]              ack;
   logic [ID_W-1:0]               grant_id;
   logic                          busy;
   logic                          TxD_start;
   logic [7:0]                    TxD_data;
   logic                          TxD_busy;

   uart_tx_scheduler #(
      .N_REQ      (N_REQ),
      .WORD_BYTES (WORD_BYTES),
      .ID_W       (ID_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_data  (req_data),
      .ack       (ack),
      .grant_id  (grant_id),
      .busy      (busy),
      .TxD_start (TxD_start),
      .TxD_data  (TxD_data),
      .TxD_busy  (TxD_busy)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy from the cycle after start for 10 cycles; unaffected by scheduler reset.
   int tx_cnt = 0;
   always @(posedge clk) begin
      if (tx_cnt > 0)     tx_cnt <= tx_cnt - 1;
      else if (TxD_start) tx_cnt <= 10;
   end
   assign TxD_busy = (tx_cnt != 0);

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_bytes[$];
   int         exp_acks[$];
   int         grant_log[$];
   logic [7:0] byte_log[$];
   int         ack_count   = 0;
   int         start_count = 0;
   int         ptr_m       = 0;
   logic       prev_busy   = 1'b0;
   logic       expect_idle = 1'b0;
   logic [N_REQ-1:0]        req_snap  = '0;
   logic [N_REQ*WORD_W-1:0] data_snap = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor and reference model: predicts each grant from the requests seen in the decision cycle.
   always @(negedge clk) begin
      int id;
      int e;
      if (reset) begin
         exp_bytes.delete();
         exp_acks.delete();
         ptr_m       = 0;
         prev_busy   = 1'b0;
         expect_idle = 1'b0;
      end else begin
         if (expect_idle) begin
            check("busy_after_ack", 64'(busy), 64'(0));
            expect_idle = 1'b0;
         end
         if (busy && !prev_busy) begin
            id = -1;
            for (int i = 0; i < N_REQ; i++) begin
               int k;
               k = (ptr_m + i) % N_REQ;
               if (id < 0 && req_snap[k]) id = k;
            end
            if (id < 0) begin
               checks++;
               errors++;
               $display("FAIL grant_without_request: got grant %0d expected no grant", grant_id);
            end else begin
               check("grant_id", 64'(grant_id), 64'(id));
               grant_log.push_back(id);
`ifdef UART_TX_SCHED_HEADER_EN
               exp_bytes.push_back({4'hA, 1'b0, 3'(id)});
`endif
               for (int b = 0; b < WORD_BYTES; b++)
                  exp_bytes.push_back(data_snap[id*WORD_W + b*8 +: 8]);
               exp_acks.push_back(id);
               ptr_m = (id + 1) % N_REQ;
            end
         end
         if (TxD_start) begin
            start_count++;
            byte_log.push_back(TxD_data);
            check("start_while_txbusy", 64'(TxD_busy), 64'(0));
            if (exp_bytes.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_start: got byte %0h expected no start", TxD_data);
            end else begin
               check("tx_byte", 64'(TxD_data), 64'(exp_bytes.pop_front()));
            end
         end
         if (ack != '0) begin
            ack_count++;
            if (exp_acks.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: got %0b expected none", ack);
            end else begin
               e = exp_acks.pop_front();
               check("ack_onehot", 64'(ack), 64'(1) << e);
               check("bytes_left_at_ack", 64'(exp_bytes.size()), 64'(0));
               check("busy_in_ack", 64'(busy), 64'(1));
            end
            expect_idle = 1'b1;
         end
         prev_busy = busy;
         req_snap  = req;
         data_snap = req_data;
      end
   end

   task automatic wait_acks(input int n, input int budget);
      int target;
      int cyc;
      target = ack_count + n;
      cyc    = 0;
      while (ack_count < target && cyc < budget) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      if (ack_count < target) begin
         checks++;
         errors++;
         $display("FAIL wait_acks_timeout: got %0d acks expected %0d", ack_count, target);
      end
   endtask

   task automatic wait_busy(input int budget);
      int cyc;
      cyc = 0;
      while (!busy && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!busy) begin
         checks++;
         errors++;
         $display("FAIL wait_busy_timeout: got busy 0 expected 1");
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_bytes(input string name, input logic [7:0] exp[$]);
      check({name, "_count"}, 64'(byte_log.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < byte_log.size(); i++)
         check(name, 64'(byte_log[i]), 64'(exp[i]));
   endtask

   task automatic check_grants(input string name, input int exp[$]);
      check({name, "_count"}, 64'(grant_log.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
         check(name, 64'(grant_log[i]), 64'(exp[i]));
   endtask

   initial begin
      logic [7:0]  eb[$];
      int          eg[$];
      logic [31:0] orig;
      int          acks0;
      int          starts0;
      int          cyc;

      reset    = 1'b1;
      req      = '0;
      req_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ack",       64'(ack),       64'(0));
      check("reset_grant_id",  64'(grant_id),  64'(0));
      check("reset_busy",      64'(busy),      64'(0));
      check("reset_txd_start", 64'(TxD_start), 64'(0));
      check("reset_txd_data",  64'(TxD_data),  64'(0));
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single request, literal byte order.
      byte_log.delete();
      req_data[31:0] = 32'hDEADBEEF;
      req            = 4'b0001;
      wait_busy(20);
      req = 4'b0000;
      wait_acks(1, 300);
      eb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef UART_TX_SCHED_HEADER_EN
      eb.push_front(8'hA0);
`endif
      check_bytes("single_bytes", eb);

      // All requesters held from pointer 0.
      pulse_reset();
      grant_log.delete();
      req_data = {$urandom, $urandom, $urandom, $urandom};
      req      = 4'b1111;
      wait_acks(5, 1500);
      req = 4'b0000;
      eg = '{0, 1, 2, 3, 0};
      check_grants("all_req_order", eg);
      repeat (3) @(posedge clk);
      #1;

      // Fairness: req0 held, req2 raised during word 0.
      pulse_reset();
      grant_log.delete();
      req = 4'b0001;
      wait_busy(20);
      repeat (5) @(posedge clk);
      #1;
      req[2] = 1'b1;
      wait_acks(3, 1000);
      req = 4'b0000;
      eg = '{0, 2, 0};
      check_grants("fair_order", eg);
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of byte 2 of requester 1.
      starts0         = start_count;
      req_data[63:32] = $urandom;
      req             = 4'b0010;
      cyc = 0;
`ifdef UART_TX_SCHED_HEADER_EN
      while (start_count < starts0 + 4 && cyc < 300) begin
`else
      while (start_count < starts0 + 3 && cyc < 300) begin
`endif
         @(posedge clk);
         cyc++;
      end
      repeat (3) @(posedge clk);
      #1;
      acks0 = ack_count;
      reset = 1'b1;
      #1;
      check("midreset_ack",       64'(ack),       64'(0));
      check("midreset_busy",      64'(busy),      64'(0));
      check("midreset_grant_id",  64'(grant_id),  64'(0));
      check("midreset_txd_start", 64'(TxD_start), 64'(0));
      check("midreset_txd_data",  64'(TxD_data),  64'(0));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      byte_log.delete();
      wait_busy(20);
      check("midreset_no_ack", 64'(ack_count), 64'(acks0));
      req = 4'b0000;
      wait_acks(1, 400);
      eb.delete();
`ifdef UART_TX_SCHED_HEADER_EN
      eb.push_back(8'hA1);
`endif
      for (int b = 0; b < WORD_BYTES; b++) eb.push_back(req_data[32 + b*8 +: 8]);
      check_bytes("restart_bytes", eb);

      // Data changed one cycle after grant must not reach the line.
      byte_log.delete();
      orig            = $urandom;
      req_data[63:32] = orig;
      req             = 4'b0010;
      wait_busy(20);
      req_data[63:32] = ~orig;
      req             = 4'b0000;
      wait_acks(1, 400);
      eb.delete();
`ifdef UART_TX_SCHED_HEADER_EN
      eb.push_back(8'hA1);
`endif
      for (int b = 0; b < WORD_BYTES; b++) eb.push_back(orig[b*8 +: 8]);
      check_bytes("capture_bytes", eb);

      // Requester 2 with word 01020304.
      byte_log.delete();
      req_data[95:64] = 32'h01020304;
      req             = 4'b0100;
      wait_busy(20);
      req = 4'b0000;
      wait_acks(1, 400);
      eb = '{8'h04, 8'h03, 8'h02, 8'h01};
`ifdef UART_TX_SCHED_HEADER_EN
      eb.push_front(8'hA2);
`endif
      check_bytes("req2_bytes", eb);

      // Random traffic: raise, drop, hold and rewrite requests freely.
      for (int c = 0; c < 2500; c++) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < N_REQ; k++) begin
            if (!req[k]) begin
               if ($urandom_range(7) == 0) begin
                  req[k] = 1'b1;
                  req_data[k*WORD_W +: WORD_W] = $urandom;
               end
            end else begin
               if ($urandom_range(15) == 0)     req[k] = 1'b0;
               else if ($urandom_range(7) == 0) req_data[k*WORD_W +: WORD_W] = $urandom;
            end
         end
      end
      req = 4'b0000;
      cyc = 0;
      while ((busy || exp_acks.size() != 0) && cyc < 500) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("drain_pending_acks",  64'(exp_acks.size()),  64'(0));
      check("drain_pending_bytes", 64'(exp_bytes.size()), 64'(0));
      check("drain_busy",          64'(busy),             64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
